sram_array_1p_param_clr: RTL and testbench
==========================================

SRAM_ARRAY_1P_PARAM_CLR -- requirements
Module: sram_array_1p_param_clr

Interface
REQ-001 SHALL have parameter DEPTH, default 128, meaning number of entries (>=2; need not be a power of two).
REQ-002 SHALL have parameter WIDTH, default 76, meaning the data bits per entry.
REQ-003 SHALL have parameter MASK_GRAN, default 1, meaning the data bits per write-mask bit (WIDTH divisible by MASK_GRAN).
REQ-004 SHALL derive ADDR_W = max(1, clog2(DEPTH)) and MASK_W = WIDTH/MASK_GRAN as localparams.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, which is asynchronous and active-high.
REQ-007 SHALL have port RW0_addr, input, ADDR_W bits: access address.
REQ-008 SHALL have port RW0_en, input, 1 bit: access request.
REQ-009 SHALL have port RW0_wmode, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port RW0_wmask, input, MASK_W bits: per-granule write enable.
REQ-011 SHALL have port RW0_wdata, input, WIDTH bits: write data.
REQ-012 SHALL have port clr_req, input, 1 bit: request a full-array clear sweep.
REQ-013 SHALL have port RW0_ready, output, 1 bit: the array accepts accesses this cycle.
REQ-014 SHALL have port RW0_rvalid, output, 1 bit: one-cycle pulse when RW0_rdata carries new read data.
REQ-015 SHALL have port RW0_rdata, output, WIDTH bits: registered read data.

Function
REQ-016 SHALL implement FSM states INIT and IDLE; RW0_ready = (state == IDLE).
REQ-017 In INIT the block SHALL write all-zero to entry clr_ptr each cycle and increment clr_ptr; when the zero write hits DEPTH-1 it SHALL enter IDLE next cycle, so a sweep takes exactly DEPTH cycles.
REQ-018 An access SHALL be accepted only when RW0_en && RW0_ready; RW0_en while not ready SHALL be dropped with no side effect and no rvalid.
REQ-019 An accepted write SHALL update bits [i*MASK_GRAN +: MASK_GRAN] only where RW0_wmask[i]=1; other bits keep their value.
REQ-020 An accepted read SHALL drive RW0_rdata with the entry contents on the next cycle (latency 1), with RW0_rvalid=1 for exactly that cycle.
REQ-021 RW0_rdata SHALL hold its last read value until the next accepted read; writes, sweeps and dropped requests SHALL NOT change it.
REQ-022 An accepted read SHALL observe the contents as of before any write in the same cycle (single port: no same-cycle read/write).
REQ-023 An address >= DEPTH SHALL make a write a no-op, and a read SHALL return all-zero with rvalid.
REQ-024 clr_req in IDLE SHALL move the FSM to INIT with clr_ptr=0 on the next cycle; any access accepted in that same cycle SHALL complete normally.
REQ-025 clr_req during INIT SHALL be ignored; the sweep SHALL NOT restart.

Reset
REQ-026 Asserting rst SHALL immediately set state=INIT, clr_ptr=0, RW0_ready=0, RW0_rvalid=0 and RW0_rdata=0.
REQ-027 Storage SHALL NOT be reset directly; its contents SHALL be zeroed only by the post-reset sweep.
REQ-028 Reset asserted mid-sweep or mid-read SHALL abandon the operation; after deassertion a full DEPTH-cycle sweep SHALL start from entry 0.

Structure
REQ-029 Package sram_pkg SHALL hold the FSM state enum (INIT, IDLE) and the address/mask width helper functions.
REQ-030 Storage SHALL be one sub-module, sram_1p_mem (DEPTH x WIDTH, granule write mask, one read/write port, no reset); the FSM, muxing and read register SHALL live in the top.

Verification
REQ-031 Reset then idle (defaults): RW0_ready low for exactly 128 cycles after rst deassert, then high; a read of addr 0x7F returns 0 with rvalid.
REQ-032 Write addr 5 data 76'hABC mask all-ones, then read addr 5: rdata=76'hABC one cycle after acceptance, rvalid a single-cycle pulse.
REQ-033 With MASK_GRAN=4: write all-ones, then write 0 with mask 19'h00001; a read returns all-ones except bits [3:0]=0.
REQ-034 Write addr 9, then pulse clr_req together with a read of addr 9: the read returns the written data; ready drops 1 cycle later for 128 cycles; a later read of addr 9 returns 0.
REQ-035 Assert rst at sweep cycle 40 and when a read is in flight: rdata=0, rvalid=0 immediately; a full 128-cycle sweep follows deassert.
REQ-036 With DEPTH=100: a write to addr 120 is a no-op; a read of addr 120 returns 0; the sweep lasts 100 cycles; RW0_en during the sweep produces no rvalid.

Source files
------------

// File: rtl/sram_array_1p_param_clr_pkg.sv
// Shared types and width helpers for the single-port SRAM array with clear sweep.
package sram_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        IDLE = 1'b1
    } sram_state_e;

    function automatic int calc_addr_w(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int calc_mask_w(input int width, input int gran);
        return width / gran;
    endfunction

endpackage

// File: rtl/sram_1p_mem.sv
// DEPTH x WIDTH storage with one read/write port and a granule write mask; no reset.
module sram_1p_mem #(
    parameter int DEPTH     = 128,
    parameter int WIDTH     = 76,
    parameter int MASK_GRAN = 1,
    parameter int ADDR_W    = 7,
    parameter int MASK_W    = 76
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [MASK_W-1:0] wmask,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             in_range_s;

    // Addresses past the last entry exist on the port when DEPTH is not a power of two.
    assign in_range_s = ({1'b0, addr} < DEPTH_L);

    // Masked granule write.
    always_ff @(posedge clk) begin
        if (we && in_range_s) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (wmask[i]) begin
                    mem_r[addr][i*MASK_GRAN +: MASK_GRAN] <= wdata[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    // Asynchronous read; out-of-range entries read as zero.
    always_comb begin
        rdata = {WIDTH{1'b0}};
        if (in_range_s) begin
            rdata = mem_r[addr];
        end else begin
            rdata = {WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/sram_array_1p_param_clr.sv
// Single-port SRAM array that zeroes itself with a DEPTH-cycle sweep after reset or on clr_req.
module sram_array_1p_param_clr
    import sram_pkg::*;
#(
    parameter  int DEPTH     = 128,
    parameter  int WIDTH     = 76,
    parameter  int MASK_GRAN = 1,
    localparam int ADDR_W    = calc_addr_w(DEPTH),
    localparam int MASK_W    = calc_mask_w(WIDTH, MASK_GRAN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] RW0_addr,
    input  logic              RW0_en,
    input  logic              RW0_wmode,
    input  logic [MASK_W-1:0] RW0_wmask,
    input  logic [WIDTH-1:0]  RW0_wdata,
    input  logic              clr_req,
    output logic              RW0_ready,
    output logic              RW0_rvalid,
    output logic [WIDTH-1:0]  RW0_rdata
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    sram_state_e       state_r;
    sram_state_e       state_nxt_s;
    logic [ADDR_W-1:0] clr_ptr_r;
    logic [ADDR_W-1:0] clr_ptr_nxt_s;
    logic [WIDTH-1:0]  rdata_r;
    logic              rvalid_r;
    logic              accept_s;
    logic              rd_accept_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [MASK_W-1:0] mem_wmask_s;
    logic [WIDTH-1:0]  mem_wdata_s;
    logic [WIDTH-1:0]  mem_rdata_s;

    assign RW0_ready   = (state_r == IDLE);
    assign RW0_rvalid  = rvalid_r;
    assign RW0_rdata   = rdata_r;
    assign accept_s    = RW0_en && RW0_ready;
    assign rd_accept_s = accept_s && !RW0_wmode;

    // Sweep sequencing: INIT walks clr_ptr to the last entry, IDLE waits for clr_req.
    always_comb begin
        state_nxt_s   = state_r;
        clr_ptr_nxt_s = clr_ptr_r;
        case (state_r)
            INIT: begin
                if (clr_ptr_r == LAST_PTR) begin
                    state_nxt_s   = IDLE;
                    clr_ptr_nxt_s = {ADDR_W{1'b0}};
                end else begin
                    clr_ptr_nxt_s = clr_ptr_r + ADDR_W'(1);
                end
            end
            IDLE: begin
                if (clr_req) begin
                    state_nxt_s   = INIT;
                    clr_ptr_nxt_s = {ADDR_W{1'b0}};
                end else begin
                    state_nxt_s   = IDLE;
                end
            end
            default: begin
                state_nxt_s   = INIT;
                clr_ptr_nxt_s = {ADDR_W{1'b0}};
            end
        endcase
    end

    // State and sweep pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= INIT;
            clr_ptr_r <= {ADDR_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            clr_ptr_r <= clr_ptr_nxt_s;
        end
    end

    // Storage port mux: the sweep owns the port in INIT, the user port in IDLE.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = RW0_addr;
        mem_wmask_s = RW0_wmask;
        mem_wdata_s = RW0_wdata;
        if (state_r == INIT) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = clr_ptr_r;
            mem_wmask_s = {MASK_W{1'b1}};
            mem_wdata_s = {WIDTH{1'b0}};
        end else begin
            mem_we_s    = accept_s && RW0_wmode;
        end
    end

    // Read register: only an accepted read updates rdata, so it holds across writes and sweeps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r  <= {WIDTH{1'b0}};
            rvalid_r <= 1'b0;
        end else begin
            rvalid_r <= rd_accept_s;
            if (rd_accept_s) begin
                rdata_r <= mem_rdata_s;
            end
        end
    end

    sram_1p_mem #(
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .MASK_GRAN (MASK_GRAN),
        .ADDR_W    (ADDR_W),
        .MASK_W    (MASK_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .addr  (mem_addr_s),
        .wmask (mem_wmask_s),
        .wdata (mem_wdata_s),
        .rdata (mem_rdata_s)
    );

endmodule

// File: tb/tb_sram_array_1p_param_clr.sv
// Bench for three configurations (default, MASK_GRAN=4, DEPTH=100) sharing one stimulus stream.
module tb_sram_array_1p_param_clr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        wmode = 1'b0;
    logic        clr = 1'b0;
    logic [6:0]  addr = 7'd0;
    logic [75:0] wdata = 76'd0;
    logic [75:0] bm = 76'd0;
    logic [18:0] m19 = 19'd0;
    logic [2:0]  rdy;
    logic [2:0]  rv;
    logic [75:0] rd0, rd1, rd2;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    int          dep [3] = '{128, 128, 100};
    logic [75:0] mm [3][128];
    int          left [3];
    logic [75:0] exp_rd [3];
    logic        exp_rv [3];

    always #5 clk = ~clk;

    sram_array_1p_param_clr u0 (
        .clk(clk), .rst(rst), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wmode),
        .RW0_wmask(bm), .RW0_wdata(wdata), .clr_req(clr),
        .RW0_ready(rdy[0]), .RW0_rvalid(rv[0]), .RW0_rdata(rd0)
    );

    sram_array_1p_param_clr #(.MASK_GRAN(4)) u1 (
        .clk(clk), .rst(rst), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wmode),
        .RW0_wmask(m19), .RW0_wdata(wdata), .clr_req(clr),
        .RW0_ready(rdy[1]), .RW0_rvalid(rv[1]), .RW0_rdata(rd1)
    );

    sram_array_1p_param_clr #(.DEPTH(100)) u2 (
        .clk(clk), .rst(rst), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wmode),
        .RW0_wmask(bm), .RW0_wdata(wdata), .clr_req(clr),
        .RW0_ready(rdy[2]), .RW0_rvalid(rv[2]), .RW0_rdata(rd2)
    );

    task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [75:0] rd_of(input int k);
        return (k == 0) ? rd0 : ((k == 1) ? rd1 : rd2);
    endfunction

    function automatic logic [75:0] bits_of(input int k);
        logic [75:0] r;
        r = bm;
        if (k == 1) begin
            for (int i = 0; i < 19; i++) r[4*i +: 4] = {4{m19[i]}};
        end
        return r;
    endfunction

    function automatic logic [75:0] rnd76();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[75:0];
    endfunction

    // Reference model: a sweep is a countdown of DEPTH busy cycles that leaves the array zeroed.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                left[k] = dep[k];
                exp_rd[k] = 76'd0;
                exp_rv[k] = 1'b0;
                for (int a = 0; a < 128; a++) mm[k][a] = 76'd0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                exp_rv[k] = 1'b0;
                if (left[k] > 0) begin
                    left[k] = left[k] - 1;
                end else begin
                    if (en && wmode && (int'(addr) < dep[k]))
                        mm[k][addr] = (mm[k][addr] & ~bits_of(k)) | (wdata & bits_of(k));
                    if (en && !wmode) begin
                        exp_rd[k] = (int'(addr) < dep[k]) ? mm[k][addr] : 76'd0;
                        exp_rv[k] = 1'b1;
                    end
                    if (clr) begin
                        left[k] = dep[k];
                        for (int a = 0; a < 128; a++) mm[k][a] = 76'd0;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("ready%0d", k), 76'(rdy[k]), 76'(left[k] == 0));
                chk($sformatf("rvalid%0d", k), 76'(rv[k]), 76'(exp_rv[k]));
                chk($sformatf("rdata%0d", k), rd_of(k), exp_rd[k]);
            end
        end
    end

    // One access cycle: inputs applied at a falling edge, outputs observable at the next one.
    task automatic acc(input bit we, input logic [6:0] a, input logic [75:0] d,
                       input logic [75:0] b, input logic [18:0] g, input bit c);
        en = 1'b1; wmode = we; addr = a; wdata = d; bm = b; m19 = g; clr = c;
        @(negedge clk);
        en = 1'b0; clr = 1'b0;
    endtask

    // Count busy cycles per instance while throwing random requests at the busy array.
    task automatic wait_sweep(output int c0, output int c1, output int c2);
        int c [3];
        int spur;
        bit first;
        bit done;
        c = '{0, 0, 0};
        spur = 0; first = 1'b1; done = 1'b0;
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 3; k++) begin
                if (!rdy[k]) begin
                    c[k]++;
                    if (!first && rv[k]) spur++;
                end
            end
            if (&rdy) begin
                done = 1'b1;
                break;
            end
            en = 1'($urandom); wmode = 1'($urandom); addr = 7'($urandom);
            wdata = rnd76(); bm = rnd76(); m19 = 19'($urandom);
            first = 1'b0;
            @(negedge clk);
        end
        en = 1'b0; clr = 1'b0;
        chk("sweep_done", 76'(done), 76'd1);
        chk("sweep_spurious_rvalid", 76'(spur), 76'd0);
        c0 = c[0]; c1 = c[1]; c2 = c[2];
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int c0, c1, c2;
        logic [75:0] ones;
        ones = ~76'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;
        wait_sweep(c0, c1, c2);
        chk("reset_sweep_len0", 76'(c0), 76'd128);
        chk("reset_sweep_len1", 76'(c1), 76'd128);
        chk("reset_sweep_len2", 76'(c2), 76'd100);

        acc(1'b0, 7'h7F, 76'd0, 76'd0, 19'd0, 1'b0);
        chk("read7f_rdata", rd0, 76'd0);
        chk("read7f_rvalid", 76'(rv[0]), 76'd1);
        @(negedge clk);
        chk("read7f_pulse", 76'(rv[0]), 76'd0);

        acc(1'b1, 7'd5, 76'hABC, ones, 19'h7FFFF, 1'b0);
        acc(1'b0, 7'd5, 76'd0, 76'd0, 19'd0, 1'b0);
        chk("rw5_rdata", rd0, 76'hABC);
        chk("rw5_rvalid", 76'(rv[0]), 76'd1);
        acc(1'b1, 7'd5, 76'h555, ones, 19'h7FFFF, 1'b0);
        chk("rw5_pulse", 76'(rv[0]), 76'd0);
        chk("rw5_hold", rd0, 76'hABC);

        acc(1'b1, 7'd3, ones, ones, 19'h7FFFF, 1'b0);
        acc(1'b1, 7'd3, 76'd0, 76'd1, 19'h00001, 1'b0);
        acc(1'b0, 7'd3, 76'd0, 76'd0, 19'd0, 1'b0);
        chk("gran4_mask", rd1, {{72{1'b1}}, 4'h0});
        chk("gran1_mask", rd0, {{75{1'b1}}, 1'b0});

        acc(1'b1, 7'd120, ones, ones, 19'h7FFFF, 1'b0);
        acc(1'b0, 7'd120, 76'd0, 76'd0, 19'd0, 1'b0);
        chk("oor_rdata", rd2, 76'd0);
        chk("oor_rvalid", 76'(rv[2]), 76'd1);
        chk("inrange120", rd0, ones);

        acc(1'b1, 7'd9, 76'h123_4567_89AB_CDEF_0123, ones, 19'h7FFFF, 1'b0);
        chk("pre_clr_ready", 76'(rdy[0]), 76'd1);
        acc(1'b0, 7'd9, 76'd0, 76'd0, 19'd0, 1'b1);
        chk("clr_read_rdata", rd0, 76'h123_4567_89AB_CDEF_0123);
        chk("clr_read_rvalid", 76'(rv[0]), 76'd1);
        wait_sweep(c0, c1, c2);
        chk("clr_sweep_len0", 76'(c0), 76'd128);
        chk("clr_sweep_len2", 76'(c2), 76'd100);
        acc(1'b0, 7'd9, 76'd0, 76'd0, 19'd0, 1'b0);
        chk("after_clr_read9", rd0, 76'd0);

        acc(1'b0, 7'd0, 76'd0, 76'd0, 19'd0, 1'b1);
        repeat (39) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_sweep_ready", 76'(rdy[0]), 76'd0);
        chk("rst_sweep_rvalid", 76'(rv[0]), 76'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_sweep(c0, c1, c2);
        chk("rst_sweep_len0", 76'(c0), 76'd128);

        acc(1'b1, 7'd7, 76'hF0F0, ones, 19'h7FFFF, 1'b0);
        acc(1'b0, 7'd7, 76'd0, 76'd0, 19'd0, 1'b0);
        chk("inflight_rdata", rd0, 76'hF0F0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_read_rdata", rd0, 76'd0);
        chk("rst_read_rvalid", 76'(rv[0]), 76'd0);
        chk("rst_read_ready", 76'(rdy[0]), 76'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_sweep(c0, c1, c2);
        chk("rst_read_sweep0", 76'(c0), 76'd128);
        chk("rst_read_sweep2", 76'(c2), 76'd100);

        for (int n = 0; n < 3000; n++) begin
            en = 1'($urandom); wmode = 1'($urandom); addr = 7'($urandom);
            wdata = rnd76(); bm = rnd76(); m19 = 19'($urandom);
            clr = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        en = 1'b0; clr = 1'b0;
        repeat (2) @(negedge clk);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
